// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiplier.
// State encoding, station tags and default widths live here.
package mult_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_BPC   = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned NOTAG  = 0;
    localparam int unsigned MULT_1 = 4;
    localparam int unsigned MULT_2 = 5;
endpackage

// File: rtl/mult_step.sv
// One radix-2^BPC step: acc + a * chunk, truncated to WIDTH bits.
// Purely combinational; no latency, no backpressure.
module mult_step #(
    parameter int WIDTH = 64,
    parameter int BPC   = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [BPC-1:0]   chunk_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH+BPC-1:0] pp;
    logic                 unused_pp_hi;

    // Full-width partial product; only the low WIDTH bits reach the accumulator.
    assign pp           = {{BPC{1'b0}}, a_i} * {{WIDTH{1'b0}}, chunk_i};
    assign unused_pp_hi = ^pp[WIDTH+BPC-1:WIDTH];
    assign sum_o        = acc_i + pp[WIDTH-1:0];
endmodule

// File: rtl/mult_unit.sv
// Iterative multiplier: BPC multiplier bits per cycle, WIDTH/BPC cycles per op.
// Result held on the CDB request until cdb_grant; ready only when IDLE.
// Optional MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W,
    parameter int BPC   = DEF_BPC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_flag,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             multiplier_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] result_tag,
    input  logic             cdb_grant
);
    localparam int CYCLES = WIDTH / BPC;
    localparam int CNT_W  = $clog2(CYCLES + 1);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] tag_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] result_tag_q;
    logic             last_step;

    mult_step #(
        .WIDTH(WIDTH),
        .BPC  (BPC)
    ) u_step (
        .acc_i  (acc_q),
        .a_i    (a_sh_q),
        .chunk_i(b_sh_q[BPC-1:0]),
        .sum_o  (acc_d)
    );

    always_comb begin
        a_sh_d  = a_sh_q << BPC;
        b_sh_d  = b_sh_q >> BPC;
        count_d = count_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
        last_step = (count_d == CNT_W'(CYCLES)) || (b_sh_d == '0);
`else
        last_step = (count_d == CNT_W'(CYCLES));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            count_q      <= '0;
            tag_q        <= TAG_W'(NOTAG);
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            result_q     <= '0;
            result_tag_q <= TAG_W'(NOTAG);
        end else begin
            case (state_q)
                IDLE: begin
                    if (mult_flag) begin
                        a_sh_q  <= op_a;
                        b_sh_q  <= op_b;
                        tag_q   <= tag_in;
                        acc_q   <= '0;
                        count_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    count_q <= count_d;
                    if (last_step) begin
                        result_q     <= acc_d;
                        result_tag_q <= tag_q;
                        valid_q      <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    // Result parks here; a concurrent mult_flag is not taken until IDLE.
                    if (cdb_grant) begin
                        valid_q      <= 1'b0;
                        result_tag_q <= TAG_W'(NOTAG);
                        ready_q      <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    valid_q      <= 1'b0;
                    result_tag_q <= TAG_W'(NOTAG);
                    ready_q      <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign multiplier_ready = ready_q;
    assign result_valid     = valid_q;
    assign result           = result_q;
    assign result_tag       = result_tag_q;
endmodule

// File: tb/tb_mult_unit.sv
// Directed and random bench for mult_unit against a plain-arithmetic reference.
// Build with MULT_EARLY_EXIT_EN to check the early-exit latency rule.
module tb_mult_unit;
    localparam int WIDTH  = 64;
    localparam int TAG_W  = 4;
    localparam int BPC    = 4;
    localparam int CYCLES = WIDTH / BPC;

    logic             clk = 1'b0;
    logic             rst;
    logic             mult_flag;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAG_W-1:0] tag_in;
    logic             multiplier_ready;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] result_tag;
    logic             cdb_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_unit #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .BPC  (BPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mult_flag       (mult_flag),
        .op_a            (op_a),
        .op_b            (op_b),
        .tag_in          (tag_in),
        .multiplier_ready(multiplier_ready),
        .result_valid    (result_valid),
        .result          (result),
        .result_tag      (result_tag),
        .cdb_grant       (cdb_grant)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Expected cycles from accept to result_valid.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int msb;
        if (b == '0) return 1;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
        return (msb + BPC) / BPC;
`else
        return CYCLES;
`endif
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] tag, input int gdelay, input bit tied);
        logic [WIDTH-1:0] exp_prod;
        int n;
        exp_prod = a * b;
        @(negedge clk);
        chk("ready_before_issue", {63'd0, multiplier_ready}, 64'd1);
        mult_flag = 1'b1;
        op_a      = a;
        op_b      = b;
        tag_in    = tag;
        cdb_grant = tied;
        @(posedge clk);
        #1;
        mult_flag = 1'b0;
        chk("ready_low_after_accept", {63'd0, multiplier_ready}, 64'd0);
        n = 0;
        // Junk on the inputs while busy must never be picked up.
        while (!result_valid && n < 40) begin
            op_a      = {$urandom, $urandom};
            op_b      = {$urandom, $urandom};
            tag_in    = TAG_W'($urandom);
            mult_flag = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        mult_flag = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat(b)));
        chk("result", result, exp_prod);
        chk("result_tag", {60'd0, result_tag}, {60'd0, tag});
        if (!tied) begin
            for (int k = 0; k < gdelay; k++) begin
                mult_flag = 1'($urandom);
                @(posedge clk);
                #1;
                chk("stall_valid", {63'd0, result_valid}, 64'd1);
                chk("stall_result", result, exp_prod);
                chk("stall_tag", {60'd0, result_tag}, {60'd0, tag});
                chk("stall_ready", {63'd0, multiplier_ready}, 64'd0);
            end
            cdb_grant = 1'b1;
            mult_flag = 1'b1;
        end
        @(posedge clk);
        #1;
        cdb_grant = 1'b0;
        mult_flag = 1'b0;
        chk("post_grant_valid", {63'd0, result_valid}, 64'd0);
        chk("post_grant_tag", {60'd0, result_tag}, 64'd0);
        chk("post_grant_ready", {63'd0, multiplier_ready}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mult_flag = 1'b0;
        op_a      = '0;
        op_b      = '0;
        tag_in    = '0;
        cdb_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", {63'd0, multiplier_ready}, 64'd1);
        chk("reset_valid", {63'd0, result_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_tag", {60'd0, result_tag}, 64'd0);

        run_op(64'd3, 64'd5, 4'd4, 0, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5, 0, 1'b0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 4'd4, 10, 1'b0);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        mult_flag = 1'b1;
        op_a      = 64'd3;
        op_b      = '1;
        tag_in    = 4'd4;
        @(posedge clk);
        #1;
        mult_flag = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midop_busy", {63'd0, multiplier_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midop_rst_ready", {63'd0, multiplier_ready}, 64'd1);
        chk("midop_rst_valid", {63'd0, result_valid}, 64'd0);
        chk("midop_rst_tag", {60'd0, result_tag}, 64'd0);
        run_op(64'd6, 64'd7, 4'd5, 1, 1'b0);

        run_op(64'hDEAD_BEEF_0000_0001, 64'd0, 4'd4, 0, 1'b0);
        run_op(64'h1_0000_0000, 64'h1_0000_0000, 4'd5, 2, 1'b0);
        run_op(64'd9, 64'd1, 4'd4, 0, 1'b0);
        run_op(64'h0000_0000_0000_ABCD, 64'h1000, 4'd5, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> ($urandom % 64);
            run_op(ra, rb, ($urandom % 2) ? 4'd4 : 4'd5, int'($urandom % 4), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multi-cycle integer multiplier, the functional unit directly downstream of the multiplier reservation stations.
- Accepts one operand pair plus its station tag when idle.
- Computes the product radix-2^BPC, one chunk per cycle.
- Holds the result on its CDB request port until the CDB arbiter grants it.
- Its idle indication gates upstream dispatch.

Parameters:
- WIDTH, 64, operand and result width in bits.
- TAG_W, 4, station tag width.
- BPC, 4, multiplier bits retired per cycle; must divide WIDTH. CYCLES = WIDTH/BPC (16 by default).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mult_flag  in  1  upstream has a ready entry; operands valid this cycle.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- tag_in  in  TAG_W  issuing station tag (4 = mult_1, 5 = mult_2).
- multiplier_ready  out  1  unit idle, will accept this cycle.
- result_valid  out  1  result pending on CDB request.
- result  out  WIDTH  low WIDTH bits of op_a*op_b.
- result_tag  out  TAG_W  tag of pending result; 0 (notag) when none.
- cdb_grant  in  1  arbiter accepts result this cycle.

Behaviour:
- Reset: state=IDLE; multiplier_ready=1; result_valid=0; result=0; result_tag=0; internal acc, a_sh, b_sh, count cleared.
- States:
  - IDLE: multiplier_ready=1.
  - CALC: multiplier_ready=0, result_valid=0.
  - DONE: result_valid=1, multiplier_ready=0.
- Accept: edge where state=IDLE and mult_flag=1.
  - Latch a_sh=op_a, b_sh=op_b, tag=tag_in, acc=0, count=0.
  - Go to CALC.
  - Inputs are ignored at all other times; upstream may change or hold them freely.
- CALC update, each edge:
  - acc <= (acc + a_sh*b_sh[BPC-1:0]) mod 2^WIDTH.
  - a_sh <<= BPC (zero fill).
  - b_sh >>= BPC (zero fill).
  - count++.
  - On the edge where count reaches CYCLES, go to DONE with result=acc_next and result_tag=tag.
- Latency: result_valid rises exactly CYCLES edges after the accept edge (16 by default).
- Arithmetic: unsigned; product truncated to low WIDTH bits; no overflow flag. Partial product a_sh*chunk is computed WIDTH+BPC wide, then truncated.
- DONE: result and result_tag stay stable until the cdb_grant edge. That edge goes to IDLE with result_valid=0 and result_tag=0; multiplier_ready=1 from the next cycle.
- cdb_grant outside DONE: ignored.
- mult_flag in the same cycle as a grant in DONE: ignored (ready still 0); upstream retries.
- Reset mid-CALC or mid-DONE: operation discarded, no result emitted, IDLE next cycle.
- Back-to-back: minimum issue interval is CYCLES+2 cycles with immediate grant.

Optional Feature:
- Macro MULT_EARLY_EXIT_EN.
- Defined: a CALC edge whose b_sh_next == 0 goes to DONE immediately with result=acc_next. Latency becomes ceil((msb_index(op_b)+1)/BPC), minimum 1 (op_b=0 gives 1).
- Undefined: latency is always CYCLES. Results are identical either way.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - tag constants NOTAG=0, MULT_1=4, MULT_2=5;
  - default WIDTH/TAG_W.
- One sub-module, mult_step: combinational acc + a_sh*chunk truncated to WIDTH.
- The FSM, counter and shift registers stay in mult_unit.

Test Plan:
- Basic: accept op_a=3, op_b=5, tag_in=4; cdb_grant tied 1 → result_valid high 16 cycles after accept, result=15, result_tag=4; multiplier_ready=1 two cycles after accept+16.
- Truncation: op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2, tag 5 → result=64'hFFFF_FFFF_FFFF_FFFE, result_tag=5.
- Grant stall: hold cdb_grant=0 for 10 cycles after valid, then pulse → result/tag stable throughout; mult_flag pulses during CALC/DONE ignored (no second accept, operands unchanged).
- Reset mid-op: assert rst at CALC count=7 → next cycle multiplier_ready=1, result_valid=0, result_tag=0; a new 6*7 op then yields 42.
- Zero/large: op_b=0 → result 0 after 16 cycles (1 cycle with MULT_EARLY_EXIT_EN). op_a=op_b=64'h1_0000_0000 → result 0.
- Early exit (MULT_EARLY_EXIT_EN): op_a=9, op_b=1 → valid after 1 cycle, result 9. op_b=16'h1000 → valid after 4 cycles.
